// File: rtl/jt10_adpcm_rom_arb_pkg.sv
// Shared definitions for the ADPCM ROM arbiter: FSM state codes and requester ids.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package jt10_adpcm_rom_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_A = 2'd1,
        ST_BUSY_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/jt10_adpcm_rom_arb_slot.sv
// One-entry byte cache for a single ADPCM requester, plus its hit / need-fetch compare.
// Latency: ok is combinational on req/addr; a fill is visible one cycle after the fill strobe.
// Backpressure: none; the requester simply holds req until ok rises.
//
// Ports: clk/rst; req/addr from the engine; fill/fill_addr/fill_data write the cache;
//        inval clears valid; ok/data back to the engine; need tells the arbiter to fetch.
module jt10_rom_slot #(
    parameter int AW = 24,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [AW-1:0] addr,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data,
    input  logic          inval,
    output logic          ok,
    output logic [DW-1:0] data,
    output logic          need
);

    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        // A completed read always wins over an invalidate in the same cycle.
        if (fill) begin
            addr_d  = fill_addr;
            data_d  = fill_data;
            valid_d = 1'b1;
        end else if (inval) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign ok   = req & valid_q & (addr_q == addr);
    assign need = req & ~ok;
    assign data = data_q;

endmodule

// File: rtl/jt10_adpcm_rom_arb.sv
// Shares one memory read port between ADPCM-A and ADPCM-B, round-robin, with per-engine byte cache.
// Latency: miss at N -> mem_rd at N+1 -> ack at M -> ok at M+1; cache hit is same-cycle.
// Backpressure: one outstanding read; mem_rd held until mem_ack or TO_CYC-cycle timeout.
//
// Ports: clk, rst (async, high); a_req/a_addr/a_data/a_ok and b_* per engine;
//        mem_addr/mem_rd/mem_ack/mem_din to the memory controller; err sticky timeout flag.
module jt10_adpcm_rom_arb
    import jt10_adpcm_rom_arb_pkg::*;
#(
    parameter int AW     = 24,
    parameter int DW     = 8,
    parameter int TO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    output logic [DW-1:0] a_data,
    output logic          a_ok,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    output logic [DW-1:0] b_data,
    output logic          b_ok,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_din,
    output logic          err
);

    localparam int TW = $clog2(TO_CYC + 1);
    // The timer starts at 0 in the first mem_rd cycle, so TO_CYC-1 marks the last allowed cycle.
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

    arb_state_t    state_q, state_d;
    req_id_t       rr_q, rr_d;
    logic          mem_rd_q, mem_rd_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;

    logic a_need, b_need;
    logic a_fill, b_fill;
    logic a_inval, b_inval;
    logic grant_a, grant_b;

    jt10_rom_slot #(.AW(AW), .DW(DW)) u_slot_a (
        .clk       (clk),
        .rst       (rst),
        .req       (a_req),
        .addr      (a_addr),
        .fill      (a_fill),
        .fill_addr (mem_addr_q),
        .fill_data (mem_din),
        .inval     (a_inval),
        .ok        (a_ok),
        .data      (a_data),
        .need      (a_need)
    );

    jt10_rom_slot #(.AW(AW), .DW(DW)) u_slot_b (
        .clk       (clk),
        .rst       (rst),
        .req       (b_req),
        .addr      (b_addr),
        .fill      (b_fill),
        .fill_addr (mem_addr_q),
        .fill_data (mem_din),
        .inval     (b_inval),
        .ok        (b_ok),
        .data      (b_data),
        .need      (b_need)
    );

    // A takes the grant when it is alone or when a tie falls on the rr pointer.
    assign grant_a = a_need & (~b_need | (rr_q == REQ_A));
    assign grant_b = b_need & ~grant_a;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        timer_d    = timer_q;
        err_d      = err_q;
        a_fill     = 1'b0;
        b_fill     = 1'b0;
        a_inval    = 1'b0;
        b_inval    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Acks arriving here belong to no read and are dropped.
                mem_rd_d = 1'b0;
                if (grant_a || grant_b) begin
                    state_d    = grant_a ? ST_BUSY_A : ST_BUSY_B;
                    mem_addr_d = grant_a ? a_addr : b_addr;
                    mem_rd_d   = 1'b1;
                    timer_d    = '0;
                    if (a_need && b_need) begin
                        rr_d = other_req(rr_q);
                    end
                end
            end
            ST_BUSY_A, ST_BUSY_B: begin
                if (mem_ack) begin
                    // Store whatever was fetched even if the requester moved on.
                    a_fill   = (state_q == ST_BUSY_A);
                    b_fill   = (state_q == ST_BUSY_B);
                    mem_rd_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (timer_q == TO_LAST) begin
                    a_inval  = (state_q == ST_BUSY_A);
                    b_inval  = (state_q == ST_BUSY_B);
                    mem_rd_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                mem_rd_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_q       <= REQ_A;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            timer_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign err      = err_q;

endmodule
